max7219_spi_capture: RTL

Avalon-MM slave that monitors the three MAX7219 serial lines (DIN, CLK, LOAD) driven by the HPS through the output PIOs, decodes them as a MAX7219 would, and queues each latched 16-bit command word in a small FIFO for readback. It is the receiving end of the bit-banged display link. Software uses it to self-check the driver without scoping the matrix. It sits on the lightweight HPS-to-FPGA bridge next to the DIN/CLK/LOAD PIOs, with its inputs tapped from the PIO `out_port` nets.

---
 rtl/max7219_spi_capture_if.sv | 20 ++
 rtl/max7219_spi_capture.sv | 120 ++++++++++++
 2 files changed

// File: rtl/max7219_spi_capture_if.sv
// Avalon-MM slave bus for the MAX7219 capture block.
// The master side is the lightweight HPS bridge and the slave side is the capture core.
interface max7219_spi_capture_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        read_n;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, read_n, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, read_n, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/max7219_spi_capture.sv
// Listens to the bit-banged MAX7219 DIN/CLK/LOAD lines and decodes them like the chip does.
// Each latched 16-bit word is queued in a small FIFO so software can read it back.
module max7219_spi_capture #(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    max7219_spi_capture_if.slave bus,
    input  logic spi_din,
    input  logic spi_clk,
    input  logic spi_load,
    output logic irq
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LW = AW + 1;

    logic [SYNC_STAGES-1:0] sync_din, sync_clk, sync_load;
    logic                   edge_clk, edge_load;
    logic                   din_s, clk_s, load_s, clk_rise, load_rise;

    logic [15:0]   sh;
    logic [4:0]    bitcnt;
    logic          enable, irq_en, overflow, short_frame;
    logic [15:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [LW-1:0] level;
    logic          empty, full, pop, frame_end, push, push_ok, ctrl_wr, sts_wr;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_din  <= '0;
            sync_clk  <= '0;
            sync_load <= '0;
            edge_clk  <= 1'b0;
            edge_load <= 1'b0;
        end else begin
            sync_din  <= {sync_din[SYNC_STAGES-2:0], spi_din};
            sync_clk  <= {sync_clk[SYNC_STAGES-2:0], spi_clk};
            sync_load <= {sync_load[SYNC_STAGES-2:0], spi_load};
            edge_clk  <= sync_clk[SYNC_STAGES-1];
            edge_load <= sync_load[SYNC_STAGES-1];
        end
    end

    assign din_s     = sync_din[SYNC_STAGES-1];
    assign clk_s     = sync_clk[SYNC_STAGES-1];
    assign load_s    = sync_load[SYNC_STAGES-1];
    assign clk_rise  = clk_s & ~edge_clk;
    assign load_rise = load_s & ~edge_load;

    assign empty     = (level == '0);
    assign full      = (level == LW'(FIFO_DEPTH));
    assign pop       = bus.chipselect & ~bus.read_n & (bus.address == 2'd0) & ~empty;
    assign frame_end = enable & load_rise;
    assign push      = frame_end & (bitcnt >= 5'd16);
    // A full FIFO still accepts the word when the head leaves on the same edge.
    assign push_ok   = push & (~full | pop);
    assign ctrl_wr   = bus.chipselect & ~bus.write_n & (bus.address == 2'd2);
    assign sts_wr    = bus.chipselect & ~bus.write_n & (bus.address == 2'd1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sh     <= '0;
            bitcnt <= '0;
        end else if (!enable || frame_end) begin
            bitcnt <= '0;
        end else if (clk_rise && !load_s) begin
            sh <= {sh[14:0], din_s};
            if (bitcnt != 5'd31)
                bitcnt <= bitcnt + 5'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= sh;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            level       <= '0;
            enable      <= 1'b0;
            irq_en      <= 1'b0;
            overflow    <= 1'b0;
            short_frame <= 1'b0;
            irq         <= 1'b0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (push_ok && !pop)
                level <= level + LW'(1);
            else if (pop && !push_ok)
                level <= level - LW'(1);
            if (ctrl_wr) begin
                enable <= bus.writedata[0];
                irq_en <= bus.writedata[1];
            end
            // A new event in the same cycle as a clear wins, so nothing is lost.
            overflow    <= (overflow & ~(sts_wr & bus.writedata[2])) | (push & full & ~pop);
            short_frame <= (short_frame & ~(sts_wr & bus.writedata[3])) |
                           (frame_end & (bitcnt < 5'd16));
            irq         <= irq_en & ~empty;
        end
    end

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            2'd0: if (!empty) bus.readdata[15:0] = mem[rd_ptr];
            2'd1: bus.readdata[7:0] = {4'(level), short_frame, overflow, full, empty};
            2'd2: bus.readdata[1:0] = {irq_en, enable};
            default: bus.readdata[4:0] = bitcnt;
        endcase
    end
endmodule
